// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources (ALU = A, load unit = B),
// the arbiter, and the register file write port / decode hazard logic.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    logic            a_valid;
    logic [4:0]      a_addr;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [4:0]      b_addr;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            stall;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;
    logic            grant_src;

    // Writeback sources, debug stall and the register file side.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pending, grant_src
    );

    // The arbiter itself.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, pending, grant_src
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// (source A) and the load unit (source B). The winning write is registered
// into a one-deep output stage; x0 writes are accepted but never committed.
//
// state  | meaning
// -------+---------------------------------------------
// PRIO_A | A wins when both sources request
// PRIO_B | B wins when both sources request
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e           prio_q;
    prio_e           prio_d;
    logic            grant_a;
    logic            grant_b;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_data;
    logic            we_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic            src_q;
    logic [NREG-1:0] pend;

    // Grant decision: stall blocks everything, a lone requester always wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!bus.stall) begin
            grant_a = bus.a_valid && (!bus.b_valid || prio_q == PRIO_A);
            grant_b = bus.b_valid && (!bus.a_valid || prio_q == PRIO_B);
        end
    end

    // Next priority: point at the source that did not just win; hold on idle.
    always_comb begin
        prio_d = prio_q;
        if (grant_a) begin
            prio_d = PRIO_B;
        end else if (grant_b) begin
            prio_d = PRIO_A;
        end
    end

    // Priority state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Select the winning address/data for the output stage.
    always_comb begin
        win_addr = bus.a_addr;
        win_data = bus.a_data;
        if (grant_b) begin
            win_addr = bus.b_addr;
            win_data = bus.b_data;
        end
    end

    // Output stage: capture the granted write; x0 targets never raise we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            src_q   <= 1'b0;
        end else begin
            we_q <= (grant_a || grant_b) && (win_addr != 5'd0);
            if (grant_a || grant_b) begin
                waddr_q <= win_addr;
                wdata_q <= win_data;
                src_q   <= grant_b;
            end
        end
    end

    // Hazard mask: requested or staged-but-uncommitted writes; x0 never pends.
    always_comb begin
        pend = '0;
        for (int r = 1; r < NREG; r++) begin
            if ((bus.a_valid && bus.a_addr == 5'(r)) ||
                (bus.b_valid && bus.b_addr == 5'(r)) ||
                (we_q && waddr_q == 5'(r))) begin
                pend[r] = 1'b1;
            end
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.grant_src = src_q;
    assign bus.pending   = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a transaction-level model tracks who should
// win each cycle, what the register file should receive and what the hazard
// mask should be; directed scenarios add hand-computed literal checks.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // who(): 0 = nobody, 1 = A, 2 = B
    logic            m_prefer_b;
    logic            m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic            m_src;
    logic [XLEN-1:0] m_rf  [NREG];
    logic [XLEN-1:0] dut_rf[NREG];

    function automatic int who();
        if (bus.stall) return 0;
        if (bus.a_valid && bus.b_valid) return m_prefer_b ? 2 : 1;
        if (bus.a_valid) return 1;
        if (bus.b_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_prefer_b <= 1'b0;
            m_we       <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
            m_src      <= 1'b0;
        end else begin
            if (m_we) m_rf[m_waddr] <= m_wdata;
            w = who();
            m_we <= 1'b0;
            if (w == 1) begin
                m_prefer_b <= 1'b1;
                m_we    <= (bus.a_addr != 0);
                m_waddr <= bus.a_addr;
                m_wdata <= bus.a_data;
                m_src   <= 1'b0;
            end else if (w == 2) begin
                m_prefer_b <= 1'b0;
                m_we    <= (bus.b_addr != 0);
                m_waddr <= bus.b_addr;
                m_wdata <= bus.b_data;
                m_src   <= 1'b1;
            end
        end
    end

    // Shadow register file driven by the DUT's write port.
    always @(posedge clk) begin
        if (rst_n && bus.rf_we) dut_rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NREG-1:0] exp_pend;
        int w;
        w = who();
        exp_pend = '0;
        for (int r = 1; r < NREG; r++) begin
            if (bus.a_valid && int'(bus.a_addr) == r) exp_pend[r] = 1'b1;
            if (bus.b_valid && int'(bus.b_addr) == r) exp_pend[r] = 1'b1;
            if (m_we && int'(m_waddr) == r)           exp_pend[r] = 1'b1;
        end
        check("model_a_ready", 64'(bus.a_ready), 64'(w == 1));
        check("model_b_ready", 64'(bus.b_ready), 64'(w == 2));
        check("model_rf_we",   64'(bus.rf_we),   64'(m_we));
        check("model_pending", 64'(bus.pending), 64'(exp_pend));
        if (m_we) begin
            check("model_rf_waddr",  64'(bus.rf_waddr),  64'(m_waddr));
            check("model_rf_wdata",  64'(bus.rf_wdata),  64'(m_wdata));
            check("model_grant_src", 64'(bus.grant_src), 64'(m_src));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.stall   = 1'b0;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad, input logic [XLEN-1:0] d);
        bus.a_valid = v;
        bus.a_addr  = ad;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad, input logic [XLEN-1:0] d);
        bus.b_valid = v;
        bus.b_addr  = ad;
        bus.b_data  = d;
    endtask

    logic [3:0] srcs;

    initial begin
        rst_n = 1'b0;
        idle();
        drive_a(1'b0, 5'd0, '0);
        drive_b(1'b0, 5'd0, '0);
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = '0;
            dut_rf[r] = '0;
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset: load the output stage and prio, then reset mid-cycle.
        drive_a(1'b1, 5'd9, 32'h55);
        step();
        drive_a(1'b1, 5'd12, 32'hC);
        drive_b(1'b1, 5'd13, 32'hD);
        check("pre_reset_we", 64'(bus.rf_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_we",    64'(bus.rf_we),     64'd0);
        check("reset_waddr", 64'(bus.rf_waddr),  64'd0);
        check("reset_wdata", 64'(bus.rf_wdata),  64'd0);
        check("reset_src",   64'(bus.grant_src), 64'd0);
        check("reset_prio_a_ready", 64'(bus.a_ready), 64'd1);
        check("reset_prio_b_ready", 64'(bus.b_ready), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_first_src",  64'(bus.grant_src), 64'd0);
        check("post_reset_first_addr", 64'(bus.rf_waddr),  64'd12);
        idle();
        step();

        // Single source A to x5; prio is now B, so run a lone B first.
        drive_b(1'b1, 5'd4, 32'h44);
        step();
        idle();
        drive_a(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_pending_req", 64'(bus.pending[5]), 64'd1);
        step();
        bus.a_valid = 1'b0;
        check("single_we",    64'(bus.rf_we),      64'd1);
        check("single_waddr", 64'(bus.rf_waddr),   64'd5);
        check("single_wdata", 64'(bus.rf_wdata),   64'h0DEADBEEF);
        check("single_pending_staged", 64'(bus.pending[5]), 64'd1);
        step();
        check("single_done_we",      64'(bus.rf_we),      64'd0);
        check("single_pending_done", 64'(bus.pending[5]), 64'd0);

        // Contention: A and B held for 4 cycles; prio is B now, so lone B first.
        drive_b(1'b1, 5'd3, 32'h33);
        step();
        idle();
        drive_a(1'b1, 5'd1, 32'd1);
        drive_b(1'b1, 5'd2, 32'd2);
        #1;
        check("contend_a_ready", 64'(bus.a_ready), 64'd1);
        check("contend_b_blocked", 64'(bus.b_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            srcs[i] = bus.grant_src;
            check("contend_we", 64'(bus.rf_we), 64'd1);
        end
        check("contend_order", 64'(srcs), 64'hA);
        idle();
        step();

        // x0 drop: prio is A after ABAB; lone A then B to x0.
        drive_a(1'b1, 5'd6, 32'd6);
        step();
        idle();
        drive_b(1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_b_ready", 64'(bus.b_ready), 64'd1);
        check("x0_pending0", 64'(bus.pending[0]), 64'd0);
        step();
        idle();
        check("x0_we", 64'(bus.rf_we), 64'd0);
        drive_a(1'b1, 5'd10, 32'hA0);
        drive_b(1'b1, 5'd11, 32'hB0);
        #1;
        check("x0_prio_flipped", 64'(bus.a_ready), 64'd1);

        // Stall with both valid; prio is B after this grant.
        step();
        bus.stall = 1'b1;
        #1;
        check("stall_c1_we", 64'(bus.rf_we), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("stall_a_ready", 64'(bus.a_ready), 64'd0);
            check("stall_b_ready", 64'(bus.b_ready), 64'd0);
            step();
            check("stall_we", 64'(bus.rf_we), 64'd0);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_b_first", 64'(bus.b_ready), 64'd1);
        step();
        idle();
        check("unstall_src", 64'(bus.grant_src), 64'd1);
        check("unstall_data", 64'(bus.rf_wdata), 64'hB0);

        // Same address with prio = A.
        drive_a(1'b1, 5'd7, 32'hA);
        drive_b(1'b1, 5'd7, 32'hB);
        step();
        bus.a_valid = 1'b0;
        check("same_first", 64'(bus.rf_wdata), 64'hA);
        step();
        idle();
        check("same_second", 64'(bus.rf_wdata), 64'hB);
        step();
        step();
        check("same_final_x7",  64'(dut_rf[7]), 64'hB);
        check("model_final_x7", 64'(dut_rf[7]), 64'(m_rf[7]));
        check("final_x5",       64'(dut_rf[5]), 64'h0DEADBEEF);
        check("final_x0",       64'(dut_rf[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32-entry general-purpose register file between two writeback sources: the ALU (source A) and the load unit (source B). Each source uses a valid/ready handshake. The block grants one source per cycle using round-robin priority and registers the winning write into an output stage that drives the register file write port. It also exports a pending-write mask, which the decode stage uses for hazard stalls.

## Interface
Parameters:
- XLEN, 32, data width of a writeback
- NREG, 32, number of architectural registers; the address width is fixed at 5 bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  ALU writeback request
- a_addr  in  5  ALU destination register
- a_data  in  XLEN  ALU result
- a_ready  out  1  ALU request accepted this cycle
- b_valid  in  1  load-unit writeback request
- b_addr  in  5  load-unit destination register
- b_data  in  XLEN  load data
- b_ready  out  1  load-unit request accepted this cycle
- stall  in  1  halt all grants; used by debug halt
- rf_we  out  1  register file write_enable
- rf_waddr  out  5  register file write_addr
- rf_wdata  out  XLEN  register file write_data
- pending  out  NREG  bit r is set when a write to register r is requested but not yet committed
- grant_src  out  1  source of the current output-stage write (0 = A, 1 = B); meaningful only when rf_we = 1

## Operation
- State:
  - prio: 1 bit, 0 = A preferred, 1 = B preferred
  - output stage: rf_we, rf_waddr, rf_wdata, grant_src
- Grant logic is combinational from the valids, stall and prio:
  - stall = 1: a_ready = b_ready = 0.
  - Only A valid: a_ready = 1. Only B valid: b_ready = 1.
  - Both valid: the preferred source is granted and the other source's ready is 0.
- Round-robin update: after a grant to a source, prio points to the other source. With no grant, prio holds.
- Handshake: a transfer occurs when valid & ready on the same edge. A source holds valid, addr and data stable until accepted. The arbiter never withdraws ready within a cycle.
- Output stage loads the granted addr/data every cycle:
  - rf_we = 1 when a grant occurred and the granted addr != 0.
  - Otherwise rf_we = 0; addr/data may hold stale values.
- Writes to x0 are accepted (ready = 1) and silently dropped, so rf_we stays 0 for them.
- pending[r] = (a_valid & a_addr == r) | (b_valid & b_addr == r) | (rf_we & rf_waddr == r), for r != 0. pending[0] is always 0.
- Both sources targeting the same register in the same cycle: the two writes are arbitrated normally and commit in grant order, so the later grant wins. Ordering guarantees are upstream's responsibility.
- The output stage never back-pressures, because the register file accepts one write per cycle.

## Timing
- Reset (asynchronous, rst_n = 0): rf_we = 0, rf_waddr = 0, rf_wdata = 0, grant_src = 0, prio = 0.
  - a_ready / b_ready are combinational and depend only on the inputs and prio.
  - Reset mid-transfer discards the output-stage write. Sources re-present after reset.
- Latency:
  - Handshake at edge N → rf_we/addr/data valid during cycle N+1.
  - Register file updates at edge N+1.
  - The register file's internal write-to-read forwarding covers reads during cycle N+1.
- Throughput: one write per cycle. With both sources continuously valid, grants alternate A, B, A, B…
- Stall asserted at edge N: no handshake at N. The output stage drops rf_we at N+1. A write already in the output stage still commits at N.
- Stall deasserted: grants resume in the same cycle, using the held prio.

## Test plan
- Reset: drive rst_n low mid-cycle with a_valid = 1 → outputs 0 immediately and prio = 0. Release reset with both sources valid → A granted first.
- Single source: A writes x5 = 0xDEADBEEF at edge N → rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF in cycle N+1. pending[5] = 1 from request through cycle N+1, then 0.
- Contention: A (x1 = 1) and B (x2 = 2) held valid for 4 cycles → grant order A, B, A, B and rf_we high every cycle. The blocked source sees ready = 0 while holding its data.
- x0 drop: B writes x0 = 0x1234 → b_ready = 1, rf_we stays 0, pending[0] = 0. prio still flips to A.
- Stall: both valid, stall = 1 for 3 cycles → no readies and rf_we = 0 from the second cycle. On release, the preferred source held from before the stall is granted first.
- Same address: A x7 = 0xA and B x7 = 0xB in the same cycle with prio = 0 → commits 0xA then 0xB. Final x7 = 0xB.
